// File: rtl/de2_115_sopc_key_pio.sv
// Avalon-MM input PIO: synchronizes and debounces board inputs, captures selected edges
// and raises a level interrupt for unmasked captured edges.
module de2_115_sopc_key_pio #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_MODE       = 1,
  parameter bit          IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  // A zero-cycle debounce still needs a 1-bit counter type to stay legal.
  localparam int unsigned CntW    = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned CntLast = (DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0;
  localparam logic [CntW-1:0]  CntMax  = CntW'(CntLast);
  localparam logic [WIDTH-1:0] IdleVec = {WIDTH{IDLE_LEVEL}};

  localparam logic [1:0] AddrData = 2'd0;
  localparam logic [1:0] AddrMask = 2'd2;
  localparam logic [1:0] AddrEdge = 2'd3;

  typedef enum logic {StIdleMatch, StCounting} db_state_e;

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [CntW-1:0]  cnt_q [WIDTH];
  logic [CntW-1:0]  cnt_d [WIDTH];
  db_state_e        db_state [WIDTH];
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rise, fall, edge_set, edge_clr;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IdleVec;
      sync2_q <= IdleVec;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: the state is implied by whether sync2 disagrees with stable.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i]    = cnt_q[i];
      db_state[i] = (sync2_q[i] == stable_q[i]) ? StIdleMatch : StCounting;
    end
    if (DEBOUNCE_CYCLES == 0) begin
      stable_d = sync2_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case (db_state[i])
          StIdleMatch: cnt_d[i] = '0;
          StCounting: begin
            if (cnt_q[i] == CntMax) begin
              stable_d[i] = sync2_q[i];
              cnt_d[i]    = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + CntW'(1);
            end
          end
          default: cnt_d[i] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= IdleVec;
      prev_q   <= IdleVec;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    rise = stable_q & ~prev_q;
    fall = ~stable_q & prev_q;
    if (EDGE_MODE == 0) begin
      edge_set = rise;
    end else if (EDGE_MODE == 1) begin
      edge_set = fall;
    end else begin
      edge_set = rise | fall;
    end
  end

  // Write-1-to-clear; a coincident new edge takes priority over the clear.
  always_comb begin
    irqmask_d = irqmask_q;
    edge_clr  = '0;
    if (wr_en && (address == AddrMask)) begin
      irqmask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == AddrEdge)) begin
      edge_clr = writedata[WIDTH-1:0];
    end
    edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  assign irq = |(edgecap_q & irqmask_q);

  always_comb begin
    readdata = '0;
    case (address)
      AddrData: readdata[WIDTH-1:0] = stable_q;
      AddrMask: readdata[WIDTH-1:0] = irqmask_q;
      AddrEdge: readdata[WIDTH-1:0] = edgecap_q;
      default:  readdata = '0;
    endcase
  end

endmodule
